// File: rtl/crc_pkg.sv
// Shared CRC definitions: default widths, CRC-8 polynomial, FSM states and
// a default-width chunk fold reusable by the receive-side checker.
package crc_pkg;

  localparam int unsigned BW_DEF     = 40;
  localparam int unsigned CRC_BW_DEF = 8;
  localparam int unsigned BPC_DEF    = 8;

  localparam logic [CRC_BW_DEF-1:0] CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } crc_state_e;

  // Fold one BPC_DEF-bit chunk, MSB first, into a CRC_BW_DEF-bit remainder.
  function automatic logic [CRC_BW_DEF-1:0] crc_step(
    input logic [CRC_BW_DEF-1:0] crc,
    input logic [BPC_DEF-1:0]    data_chunk
  );
    logic [CRC_BW_DEF-1:0] c;
    logic                  fb;
    c = crc;
    for (int i = BPC_DEF - 1; i >= 0; i--) begin
      fb = data_chunk[i] ^ c[CRC_BW_DEF-1];
      c  = {c[CRC_BW_DEF-2:0], 1'b0} ^ (fb ? CRC8_POLY : '0);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_fold.sv
// Combinational BPC-bit LFSR step: folds data_in (MSB first) into crc_in.
module crc_fold
  import crc_pkg::*;
#(
  parameter int unsigned         CRC_BW = CRC_BW_DEF,
  parameter int unsigned         BPC    = BPC_DEF,
  parameter logic [CRC_BW-1:0]   POLY   = CRC_BW'(CRC8_POLY)
) (
  input  logic [CRC_BW-1:0] crc_in,
  input  logic [BPC-1:0]    data_in,
  output logic [CRC_BW-1:0] crc_out_c
);

  logic [CRC_BW-1:0] acc;
  logic              fb;

  // Unrolled per-bit steps, most significant data bit first.
  always_comb begin
    acc = crc_in;
    fb  = 1'b0;
    for (int i = BPC - 1; i >= 0; i--) begin
      fb  = data_in[i] ^ acc[CRC_BW-1];
      acc = {acc[CRC_BW-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    crc_out_c = acc;
  end

endmodule

// File: rtl/crc_transmitter.sv
// CRC transmitter: accepts a BW-bit payload, folds it BPC bits per clock and
// emits the codeword {payload, crc} on a valid/ready interface.
// Optional: CRC_TX_ERR_INJECT_EN adds err_inj, which flips codeword bit 0.
module crc_transmitter
  import crc_pkg::*;
#(
  parameter int unsigned       BW     = BW_DEF,
  parameter int unsigned       CRC_BW = CRC_BW_DEF,
  parameter logic [CRC_BW-1:0] POLY   = CRC_BW'(CRC8_POLY),
  parameter int unsigned       BPC    = BPC_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BW-1:0]        in_data,
`ifdef CRC_TX_ERR_INJECT_EN
  input  logic                 err_inj,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BW+CRC_BW-1:0] out_data
);

  localparam int unsigned NCHUNK = BW / BPC;
  localparam int unsigned CNT_W  = $clog2(NCHUNK + 1);
  localparam int unsigned CW     = BW + CRC_BW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  // Reject configurations the datapath cannot represent.
  if ((BPC == 0) || (BW % BPC != 0)) begin : g_bad_bpc
    $error("crc_transmitter: BW must be a non-zero multiple of BPC");
  end
  if (CRC_BW < 2) begin : g_bad_crc_bw
    $error("crc_transmitter: CRC_BW must be at least 2");
  end
  if (BPC > BW) begin : g_bad_bpc_wide
    $error("crc_transmitter: BPC must not exceed BW");
  end

  crc_state_e        state_q, state_d;
  logic [BW-1:0]     payload_q, payload_d;
  logic [BW-1:0]     shift_q, shift_d;
  logic [CRC_BW-1:0] crc_q, crc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              inj_q, inj_d;
  logic              in_ready_d;
  logic              out_valid_d;
  logic [CW-1:0]     out_data_d;
  logic [CRC_BW-1:0] fold_c;
  logic              err_inj_c;

  // Error-injection request seen at acceptance; constant zero when absent.
`ifdef CRC_TX_ERR_INJECT_EN
  assign err_inj_c = err_inj;
`else
  assign err_inj_c = 1'b0;
`endif

  // Single fold stage working on the top chunk of the shift register.
  crc_fold #(
    .CRC_BW (CRC_BW),
    .BPC    (BPC),
    .POLY   (POLY)
  ) u_fold (
    .crc_in    (crc_q),
    .data_in   (shift_q[BW-1 -: BPC]),
    .crc_out_c (fold_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    payload_d   = payload_q;
    shift_d     = shift_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    inj_d       = inj_q;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    out_data_d  = out_data;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          payload_d  = in_data;
          shift_d    = in_data;
          crc_d      = '0;
          cnt_d      = '0;
          inj_d      = err_inj_c;
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end

      CALC: begin
        crc_d   = fold_c;
        shift_d = shift_q << BPC;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          out_valid_d = 1'b1;
          out_data_d  = {payload_q, fold_c ^ CRC_BW'(inj_q)};
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      payload_q <= '0;
      shift_q   <= '0;
      crc_q     <= '0;
      cnt_q     <= '0;
      inj_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
      shift_q   <= shift_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      inj_q     <= inj_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_crc_transmitter.sv
// Scoreboard bench for crc_transmitter: stimulus pushes expected codewords,
// a monitor pops and compares on every output handshake and runs a
// receiver-side division model on each codeword.
module tb_crc_transmitter;

  localparam int unsigned BW     = 40;
  localparam int unsigned CRC_BW = 8;
  localparam int unsigned CW     = BW + CRC_BW;

  typedef struct packed {
    logic [CW-1:0] cw;
    logic [BW-1:0] rx;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_data;
`ifdef CRC_TX_ERR_INJECT_EN
  logic          err_inj;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  crc_transmitter dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef CRC_TX_ERR_INJECT_EN
    .err_inj   (err_inj),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Bit-serial reference: (payload * x^8) mod x^8+x^2+x+1.
  function automatic logic [CRC_BW-1:0] model_crc(input logic [BW-1:0] p);
    logic [CRC_BW-1:0] r;
    logic              fb;
    r = '0;
    for (int i = BW - 1; i >= 0; i--) begin
      fb = p[i] ^ r[CRC_BW-1];
      r  = {r[CRC_BW-2:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  // Receiver model: divides the whole codeword, returns payload or 0.
  function automatic logic [BW-1:0] rx_model(input logic [CW-1:0] cw);
    logic [CRC_BW-1:0] r;
    logic              fb;
    r = '0;
    for (int i = CW - 1; i >= 0; i--) begin
      fb = cw[i] ^ r[CRC_BW-1];
      r  = {r[CRC_BW-2:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return (r == '0) ? cw[CW-1:CRC_BW] : '0;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one payload; returns the number of cycles spent waiting for in_ready.
  task automatic send(input logic [BW-1:0] p, input logic inj, output int waits);
    waits = 0;
    while (!in_ready && waits < 30) begin
      tick();
      waits++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
    end else begin
      in_valid = 1'b1;
      in_data  = p;
`ifdef CRC_TX_ERR_INJECT_EN
      err_inj  = inj;
`else
      if (inj) $display("note: err_inj ignored in this build");
`endif
      tick();
      in_valid = 1'b0;
      in_data  = '1;
`ifdef CRC_TX_ERR_INJECT_EN
      err_inj  = 1'b0;
`endif
    end
  endtask

  task automatic push(input logic [BW-1:0] p, input logic [CRC_BW-1:0] c, input logic [BW-1:0] rx);
    exp_t e;
    e.cw = {p, c};
    e.rx = rx;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compare each handshaken codeword against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_codeword: got=%0h expected=none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("codeword", 64'(out_data), 64'(e.cw));
        chk("receiver", 64'(rx_model(out_data)), 64'(e.rx));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int cyc;
    logic [63:0] r64;
    logic [BW-1:0] p;

    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef CRC_TX_ERR_INJECT_EN
    err_inj   = 1'b0;
`endif
    repeat (3) tick();
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    rstn = 1'b1;
    tick();

    // Single frame: latency (cycle 1 begins at the accepting edge) and pulse.
    push(40'h1, 8'h07, 40'h1);
    send(40'h1, 1'b0, w);
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("latency_cycles", 64'(cyc), 64'd6);
    chk("busy_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("valid_pulse_one_cycle", 64'(out_valid), 64'd0);
    chk("ready_after_handshake", 64'(in_ready), 64'd1);

    // Back to back: 7-cycle period means 6 sampled cycles with in_ready low.
    push(40'h2, 8'h0E, 40'h2);
    send(40'h2, 1'b0, w);
    chk("b2b_first_wait", 64'(w), 64'd0);
    push(40'h3, 8'h09, 40'h3);
    send(40'h3, 1'b0, w);
    chk("b2b_wait_frame2", 64'(w), 64'd6);
    push(40'h100, 8'h15, 40'h100);
    send(40'h100, 1'b0, w);
    chk("b2b_wait_frame3", 64'(w), 64'd6);
    drain("drain_b2b");

    // Backpressure: codeword held, in_ready low, extra in_valid ignored.
    out_ready = 1'b0;
    push(40'h0, 8'h00, 40'h0);
    send(40'h0, 1'b0, w);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_data", 64'(out_data), 64'd0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b1;
      in_data  = 40'hAB_CDEF_0123;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    drain("drain_bp");

    // Reset during CALC discards the frame.
    send(40'h1, 1'b0, w);
    tick();
    tick();
    rstn = 1'b0;
    tick();
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_out_data", 64'(out_data), 64'd0);
    rstn = 1'b1;
    repeat (10) tick();
    push(40'h2, 8'h0E, 40'h2);
    send(40'h2, 1'b0, w);
    drain("drain_after_reset");

`ifdef CRC_TX_ERR_INJECT_EN
    // Injected error flips codeword bit 0; receiver rejects it.
    push(40'h1, 8'h06, 40'h0);
    send(40'h1, 1'b1, w);
    drain("drain_inject");
    push(40'h1, 8'h07, 40'h1);
    send(40'h1, 1'b0, w);
    drain("drain_inject_clear");
`endif

    // Random payloads through transmitter and receiver model.
    for (int i = 0; i < 1000; i++) begin
      r64 = {$urandom(), $urandom()};
      p   = r64[BW-1:0];
      push(p, model_crc(p), p);
      send(p, 1'b0, w);
    end
    drain("drain_random");

    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crc_transmitter.md
Name: crc_transmitter

Overview:
- Transmit-side companion to the CRC-checking receiver: accepts a BW-bit payload, computes a CRC_BW-bit CRC and emits the codeword {payload, crc}.
- Every emitted codeword gives an all-zero remainder when the receiver divides it by POLY.
- The CRC is computed iteratively (BPC bits per clock) by a small FSM.
- Uses a valid/ready handshake on both sides and sits directly in front of the link feeding the receiver.

Parameters:
- BW, 40, payload width in bits.
- CRC_BW, 8, CRC width in bits.
- POLY, 8'h07, generator polynomial without the implicit x^CRC_BW term; width CRC_BW.
- BPC, 8, payload bits folded per clock. BW % BPC must be 0; elaboration fails otherwise.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  synchronous active-low reset.
- in_valid  in  1  payload valid.
- in_ready  out  1  block can accept a payload.
- in_data  in  BW  payload.
- out_valid  out  1  codeword valid.
- out_ready  in  1  downstream accepts the codeword.
- out_data  out  BW+CRC_BW  codeword, payload in [BW+CRC_BW-1:CRC_BW], CRC in [CRC_BW-1:0].

Behaviour:
- Reset: rstn sampled low at a clk edge forces the following, overriding every other event:
  - state=IDLE, in_ready=1, out_valid=0, out_data=0;
  - internal CRC register=0, shift register=0, bit counter=0.
- Reset mid-frame discards the frame; no partial codeword is ever emitted.
- CRC definition: MSB-first, init 0, no reflection, no final XOR. crc = (payload * x^CRC_BW) mod POLY.
- Per-bit step: fb = d ^ crc[CRC_BW-1]; crc = {crc[CRC_BW-2:0],1'b0} ^ (fb ? POLY : 0).
- Per-clock step: BPC per-bit steps unrolled combinationally, payload MSB first.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch in_data into the payload and shift registers, clear crc and the counter, go to CALC.
  - CALC: in_ready=0. Each cycle fold the top BPC bits of the shift register, shift left by BPC, count++. When count reaches BW/BPC-1 (last chunk), go to DONE.
  - DONE: out_valid=1, out_data={payload,crc}, held stable until out_ready. On out_valid&&out_ready, out_valid=0 and go to IDLE.
- Latency: handshake edge to out_valid high = BW/BPC+1 cycles (6 with defaults).
- Throughput: with out_ready tied high, one frame per BW/BPC+2 cycles.
- in_data is sampled only at acceptance; later changes are ignored.
- in_valid while in_ready=0 is ignored; the upstream holds it.
- out_ready while out_valid=0 has no effect.
- No combinational path from in_valid or out_ready to any output.

Optional Feature:
- Macro: CRC_TX_ERR_INJECT_EN.
- Defined: adds port err_inj (in, 1). If err_inj=1 at input acceptance, the emitted codeword has bit 0 inverted, so the receiver sees a CRC mismatch. The flag is latched per frame.
- Undefined: port absent; codeword always correct.

Decomposition:
- Package crc_pkg holds:
  - default widths;
  - POLY constant CRC8_POLY=8'h07;
  - state enum {IDLE,CALC,DONE};
  - a function crc_step(crc, data_chunk) implementing the BPC-bit fold, so the receiver check can reuse it.
- One natural sub-module: crc_fold, a combinational BPC-bit LFSR step instantiated once in the datapath.

Test Plan:
- Reset then payload 40'h00_0000_0001, out_ready=1 -> out_data={40'h1,8'h07}, out_valid exactly 6 cycles after accept, pulse one cycle.
- Payloads 40'h2, 40'h3, 40'h100 back to back -> CRCs 8'h0E, 8'h09, 8'h15. in_ready low throughout CALC/DONE; one frame per 7 cycles.
- Backpressure: payload 40'h0, out_ready=0 for 10 cycles -> out_valid and out_data={48'h0} held; in_ready=0; a new in_valid is ignored. Asserting out_ready completes the transfer next edge.
- rstn low during CALC of 40'h1 -> next cycle in_ready=1, out_valid=0. No codeword for that frame; next frame 40'h2 gives 8'h0E.
- Random 1000 payloads through the transmitter into the receiver model -> every receiver output equals the payload.
- With CRC_TX_ERR_INJECT_EN, err_inj=1, payload 40'h1 -> out_data={40'h1,8'h06}; receiver outputs 0.
